pipelined_wallace_multiplier: RTL and testbench

PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

---
 rtl/mul_pkg.sv | 53 +++++
 rtl/fa.sv | 16 +
 rtl/ha.sv | 15 +
 rtl/wallace_csa_tree.sv | 81 ++++++++
 rtl/pipelined_wallace_multiplier.sv | 125 ++++++++++++
 tb/tb_pipelined_wallace_multiplier.sv | 346 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared constants and elaboration-time helpers for the pipelined Wallace
// multiplier:
//   WIDTH_MIN / WIDTH_MAX : legal operand width range
//   TAG_W_DEFAULT         : default sideband tag width
//   bw_correction()       : Baugh-Wooley correction constant for a w-bit
//                           signed multiply, over 2*w bits
//   wallace_*()           : row-count bookkeeping for the CSA tree levels
// ---------------------------------------------------------------------------
package mul_pkg;

   localparam int WIDTH_MIN     = 4;
   localparam int WIDTH_MAX     = 32;
   localparam int TAG_W_DEFAULT = 4;

   // Inverting the sign-row and sign-column partial products leaves a
   // constant offset of -(2^(2w-1)) + 2^w. Modulo 2^(2w), this equals
   // 2^(2w-1) + 2^w.
   function automatic logic [2*WIDTH_MAX-1:0] bw_correction(input int w);
      logic [2*WIDTH_MAX-1:0] c;
      c           = '0;
      c[w]        = 1'b1;
      c[2*w-1]    = 1'b1;
      return c;
   endfunction

   // One Wallace level: every group of three rows becomes two rows,
   // and a leftover pair or single row passes through as two or one rows.
   function automatic int wallace_next_rows(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int wallace_rows_at(input int n, input int lvl);
      int r;
      r = n;
      for (int k = 0; k < lvl; k++) r = wallace_next_rows(r);
      return r;
   endfunction

   function automatic int wallace_levels(input int n);
      int r;
      int l;
      r = n;
      l = 0;
      while (r > 2) begin
         r = wallace_next_rows(r);
         l++;
      end
      return l;
   endfunction

endpackage

// File: rtl/fa.sv
// ---------------------------------------------------------------------------
// fa : one-bit full adder (3:2 counter)
//   i_a, i_b, i_c : addend bits
//   o_s           : sum bit
//   o_c           : carry bit (weight 2)
// ---------------------------------------------------------------------------
module fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/ha.sv
// ---------------------------------------------------------------------------
// ha : one-bit half adder (2:2 counter)
//   i_a, i_b : addend bits
//   o_s      : sum bit
//   o_c      : carry bit (weight 2)
// ---------------------------------------------------------------------------
module ha (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

// File: rtl/wallace_csa_tree.sv
// ---------------------------------------------------------------------------
// wallace_csa_tree
// Combinational Wallace reduction of WIDTH partial-product rows (each
// 2*WIDTH bits, already shifted into place) down to a sum/carry pair.
//   i_rows  : WIDTH partial-product rows
//   o_sum   : carry-save sum row
//   o_carry : carry-save carry row (already shifted to its weight)
// o_sum + o_carry equals the sum of all rows modulo 2^(2*WIDTH).
// ---------------------------------------------------------------------------
module wallace_csa_tree
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] i_rows [WIDTH],
   output logic [2*WIDTH-1:0] o_sum,
   output logic [2*WIDTH-1:0] o_carry
);

   localparam int PW     = 2 * WIDTH;
   localparam int LEVELS = wallace_levels(WIDTH);

   // w_lvl[l] holds the rows entering level l; slots beyond the live row
   // count of a level are tied to zero.
   logic [PW-1:0] w_lvl [LEVELS+1][WIDTH];

   for (genvar k = 0; k < WIDTH; k++) begin : g_in
      assign w_lvl[0][k] = i_rows[k];
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N  = wallace_rows_at(WIDTH, l);
      localparam int G  = N / 3;
      localparam int NN = wallace_next_rows(N);

      for (genvar g = 0; g < G; g++) begin : g_fa
         logic [PW-1:0] w_s;
         logic [PW-2:0] w_c;
         for (genvar b = 0; b < PW - 1; b++) begin : g_bit
            fa u_fa (
               .i_a (w_lvl[l][3*g][b]),
               .i_b (w_lvl[l][3*g+1][b]),
               .i_c (w_lvl[l][3*g+2][b]),
               .o_s (w_s[b]),
               .o_c (w_c[b])
            );
         end
         // Top column: its carry would land beyond the 2*WIDTH-bit product.
         assign w_s[PW-1] = w_lvl[l][3*g][PW-1] ^ w_lvl[l][3*g+1][PW-1]
                          ^ w_lvl[l][3*g+2][PW-1];
         assign w_lvl[l+1][2*g]   = w_s;
         assign w_lvl[l+1][2*g+1] = {w_c, 1'b0};
      end

      if (N % 3 == 2) begin : g_ha
         logic [PW-1:0] w_s;
         logic [PW-2:0] w_c;
         for (genvar b = 0; b < PW - 1; b++) begin : g_bit
            ha u_ha (
               .i_a (w_lvl[l][3*G][b]),
               .i_b (w_lvl[l][3*G+1][b]),
               .o_s (w_s[b]),
               .o_c (w_c[b])
            );
         end
         assign w_s[PW-1] = w_lvl[l][3*G][PW-1] ^ w_lvl[l][3*G+1][PW-1];
         assign w_lvl[l+1][2*G]   = w_s;
         assign w_lvl[l+1][2*G+1] = {w_c, 1'b0};
      end else if (N % 3 == 1) begin : g_pass
         assign w_lvl[l+1][2*G] = w_lvl[l][3*G];
      end

      for (genvar k = NN; k < WIDTH; k++) begin : g_zero
         assign w_lvl[l+1][k] = '0;
      end
   end

   assign o_sum   = w_lvl[LEVELS][0];
   assign o_carry = w_lvl[LEVELS][1];

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_wallace_multiplier
// Three-stage signed/unsigned multiplier with valid/ready handshakes.
//   S1: Baugh-Wooley / AND partial-product matrix
//   S2: Wallace-reduced carry-save pair
//   S3: final carry-propagate sum (output register)
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   in_a, in_b            : WIDTH-bit operands
//   in_signed             : 1 = two's complement, 0 = unsigned (per operation)
//   in_tag                : opaque tag returned with the result
//   out_valid / out_ready : result handshake
//   out_product           : 2*WIDTH-bit product
//   out_tag               : tag of the operation producing out_product
// ---------------------------------------------------------------------------
module pipelined_wallace_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = TAG_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int PW = 2 * WIDTH;
   localparam logic [2*WIDTH_MAX-1:0] BW_CORR_FULL = bw_correction(WIDTH);
   localparam logic [PW-1:0] BW_CORR  = BW_CORR_FULL[PW-1:0];
   localparam logic [PW-1:0] TOP_BIT  = {1'b1, {(PW-1){1'b0}}};
   // Correction bits are folded into holes of existing rows rather than
   // adding a row: bit WIDTH is free in row 0, bit 2*WIDTH-1 in the last row.
   localparam logic [PW-1:0] CORR_LO  = BW_CORR & ~TOP_BIT;
   localparam logic [PW-1:0] CORR_HI  = BW_CORR & TOP_BIT;

   logic              r_vld_p1, r_vld_p2, r_vld_p3;
   logic [PW-1:0]     r_rows_p1 [WIDTH];
   logic [TAG_W-1:0]  r_tag_p1, r_tag_p2, r_tag_p3;
   logic [PW-1:0]     r_sum_p2, r_cry_p2, r_prod_p3;

   logic              w_adv1, w_adv2, w_adv3;
   logic [PW-1:0]     w_pp [WIDTH];
   logic [PW-1:0]     w_sum, w_cry;

   // A stage advances when it is empty or its successor advances.
   assign w_adv3   = ~r_vld_p3 | out_ready;
   assign w_adv2   = ~r_vld_p2 | w_adv3;
   assign w_adv1   = ~r_vld_p1 | w_adv2;
   assign in_ready = w_adv1;

   // ---- S1 input: partial-product matrix ----
   // Signed mode inverts the terms where exactly one factor is a sign bit.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_pp[i] = '0;
         for (int j = 0; j < WIDTH; j++) begin
            w_pp[i][i+j] = (in_a[j] & in_b[i])
                         ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
         end
      end
      if (in_signed) begin
         w_pp[0]       = w_pp[0] | CORR_LO;
         w_pp[WIDTH-1] = w_pp[WIDTH-1] | CORR_HI;
      end
   end

   // ---- S2 input: Wallace reduction to carry-save form ----
   wallace_csa_tree #(
      .WIDTH (WIDTH)
   ) u_tree (
      .i_rows  (r_rows_p1),
      .o_sum   (w_sum),
      .o_carry (w_cry)
   );

   // ---- control and output registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_vld_p3  <= 1'b0;
         r_prod_p3 <= '0;
         r_tag_p3  <= '0;
      end else begin
         if (w_adv1) r_vld_p1 <= in_valid;
         if (w_adv2) r_vld_p2 <= r_vld_p1;
         if (w_adv3) begin
            r_vld_p3 <= r_vld_p2;
            // ---- S3: carry-propagate sum ----
            if (r_vld_p2) begin
               r_prod_p3 <= r_sum_p2 + r_cry_p2;
               r_tag_p3  <= r_tag_p2;
            end
         end
      end
   end

   // ---- S1 / S2 datapath registers ----
   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) begin
         r_rows_p1 <= w_pp;
         r_tag_p1  <= in_tag;
      end
      if (w_adv2 && r_vld_p1) begin
         r_sum_p2 <= w_sum;
         r_cry_p2 <= w_cry;
         r_tag_p2 <= r_tag_p1;
      end
   end

   assign out_valid   = r_vld_p3;
   assign out_product = r_prod_p3;
   assign out_tag     = r_tag_p3;

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
module tb_pipelined_wallace_multiplier;

   localparam int TAG_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              in_valid, in_signed, out_ready;
   logic [15:0]       in_a, in_b;
   logic [TAG_W-1:0]  in_tag;

   logic              rdy4, rdy8, rdy16, vld4, vld8, vld16;
   logic [7:0]        prod4;
   logic [15:0]       prod8;
   logic [31:0]       prod16;
   logic [TAG_W-1:0]  tag4, tag8, tag16;

   pipelined_wallace_multiplier #(.WIDTH(4), .TAG_W(TAG_W)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
      .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(vld4), .out_ready(out_ready), .out_product(prod4), .out_tag(tag4));

   pipelined_wallace_multiplier #(.WIDTH(8), .TAG_W(TAG_W)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
      .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(vld8), .out_ready(out_ready), .out_product(prod8), .out_tag(tag8));

   pipelined_wallace_multiplier #(.WIDTH(16), .TAG_W(TAG_W)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(vld16), .out_ready(out_ready), .out_product(prod16), .out_tag(tag16));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]      p;
      logic [TAG_W-1:0] t;
   } exp_t;

   exp_t q4[$], q8[$], q16[$];

   // Reference: interpret the low w bits as signed or unsigned integers,
   // multiply as plain integers, keep the low 2*w bits.
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
      longint x, y, p, m;
      m = (longint'(1) << w) - 1;
      x = longint'(a) & m;
      y = longint'(b) & m;
      if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
      p = x * y;
      p = p & ((longint'(1) << (2 * w)) - 1);
      return 32'(p);
   endfunction

   function automatic logic [15:0] pick_op();
      case ($urandom % 8)
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (vld8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", vld8); end
      checks++;
      if (prod8 !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h want 0000", prod8); end
      checks++;
      if (tag8 !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag8); end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", rdy8); end
      checks++;
      if (vld8 !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", vld8); end
   endtask

   // 255*255 unsigned; the result must appear after the third rising edge
   // counting the accepting edge, and exactly once.
   task automatic test_basic();
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'd255; in_b = 16'd255; in_signed = 1'b0; in_tag = 4'd3;
      out_ready = 1'b1;
      #1;
      checks++;
      if (rdy8 !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", rdy8); end
      @(posedge clk);
      for (int e = 2; e <= 3; e++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (vld8 !== 1'b0) begin errors++; $display("FAIL basic_early_valid edge %0d: got %b want 0", e - 1, vld8); end
         @(posedge clk);
      end
      @(negedge clk);
      checks++;
      if (vld8 !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid got %b want 1", vld8); end
      checks++;
      if (prod8 !== 16'hFE01) begin errors++; $display("FAIL basic_product: got %h want fe01", prod8); end
      checks++;
      if (tag8 !== 4'd3) begin errors++; $display("FAIL basic_tag: got %0d want 3", tag8); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (vld8 !== 1'b0) begin errors++; $display("FAIL basic_duplicate: out_valid got %b want 0", vld8); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ta [3];
      logic [15:0] tb [3];
      logic        ts [3];
      logic [15:0] te [3];
      ta = '{16'h0080, 16'h00FF, 16'h00FF};
      tb = '{16'h0080, 16'h0001, 16'h0001};
      ts = '{1'b1, 1'b1, 1'b0};
      te = '{16'h4000, 16'hFFFF, 16'h00FF};
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            checks++;
            if (vld8 !== 1'b1 || prod8 !== te[c-3] || tag8 !== 4'(c - 3))
               begin errors++; $display("FAIL b2b_result%0d: got v=%b p=%h t=%0d want v=1 p=%h t=%0d",
                                        c - 3, vld8, prod8, tag8, te[c-3], c - 3); end
         end else begin
            checks++;
            if (vld8 !== 1'b0) begin errors++; $display("FAIL b2b_idle cycle %0d: out_valid got %b want 0", c, vld8); end
         end
         if (c < 3) begin
            in_valid = 1'b1; in_a = ta[c]; in_b = tb[c]; in_signed = ts[c]; in_tag = 4'(c);
            #1;
            checks++;
            if (rdy8 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready op%0d: got %b want 1", c, rdy8); end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
      end
   endtask

   // Ten operations, out_ready follows 1,0,0,1; checks ordering, output
   // stability while stalled, and when in_ready may drop.
   task automatic test_stall();
      int          sent, got, inflight, cyc;
      logic        prev_stall;
      logic [15:0] prev_p;
      logic [3:0]  prev_t;
      logic        exp_rdy;
      exp_t        e;
      sent = 0; got = 0; inflight = 0; cyc = 0; prev_stall = 1'b0;
      prev_p = '0; prev_t = '0;
      q8.delete();
      while (got < 10 && cyc < 300) begin
         @(negedge clk);
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         in_valid  = (sent < 10);
         in_a      = pick_op();
         in_b      = pick_op();
         in_signed = 1'($urandom & 1);
         in_tag    = 4'(sent);
         #1;
         if (prev_stall) begin
            checks++;
            if (vld8 !== 1'b1 || prod8 !== prev_p || tag8 !== prev_t)
               begin errors++; $display("FAIL stall_hold: got v=%b p=%h t=%0d want v=1 p=%h t=%0d",
                                        vld8, prod8, tag8, prev_p, prev_t); end
         end
         exp_rdy = !(inflight == 3 && !out_ready);
         checks++;
         if (rdy8 !== exp_rdy) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b want %b", cyc, rdy8, exp_rdy); end
         if (vld8 && out_ready) begin
            checks++;
            if (q8.size() == 0) begin
               errors++; $display("FAIL stall_spurious: got p=%h t=%0d want no output", prod8, tag8);
            end else begin
               e = q8.pop_front();
               if (prod8 !== e.p[15:0] || tag8 !== e.t)
                  begin errors++; $display("FAIL stall_result: got p=%h t=%0d want p=%h t=%0d",
                                           prod8, tag8, e.p[15:0], e.t); end
               got++;
               inflight--;
            end
         end
         prev_stall = vld8 && !out_ready;
         prev_p = prod8;
         prev_t = tag8;
         if (in_valid && rdy8) begin
            e.p = ref_mul(8, in_a, in_b, in_signed);
            e.t = in_tag;
            q8.push_back(e);
            sent++;
            inflight++;
         end
         @(posedge clk);
         cyc++;
      end
      checks++;
      if (got != 10) begin errors++; $display("FAIL stall_timeout: got %0d results want 10", got); end
      idle_inputs();
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset_flush();
      int waited;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5; in_signed = 1'b0; in_tag = 4'd1;
      @(posedge clk);
      @(negedge clk);
      in_a = 16'd9; in_b = 16'd9; in_tag = 4'd2;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (vld8 !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", vld8); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (vld8 !== 1'b0) begin errors++; $display("FAIL flush_async_valid: got %b want 0", vld8); end
      checks++;
      if (prod8 !== 16'h0000 || tag8 !== 4'h0)
         begin errors++; $display("FAIL flush_async_data: got p=%h t=%0d want p=0000 t=0", prod8, tag8); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (vld8 !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d: got out_valid %b want 0", c, vld8); end
         @(negedge clk);
      end
      in_valid = 1'b1; in_a = 16'd7; in_b = 16'd6; in_signed = 1'b0; in_tag = 4'd5;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      waited = 0;
      while (vld8 !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (vld8 !== 1'b1 || prod8 !== 16'd42 || tag8 !== 4'd5)
         begin errors++; $display("FAIL flush_next_op: got v=%b p=%0d t=%0d want v=1 p=42 t=5", vld8, prod8, tag8); end
      idle_inputs();
      repeat (4) @(posedge clk);
   endtask

   // Mixed signed/unsigned random traffic with random stalls, run through
   // the 4-, 8- and 16-bit instances at once, each with its own scoreboard.
   task automatic test_random();
      localparam int N = 10000;
      int   issued, cyc;
      exp_t e;
      issued = 0; cyc = 0;
      q4.delete(); q8.delete(); q16.delete();
      while ((issued < N || q4.size() != 0 || q8.size() != 0 || q16.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         in_valid  = (issued < N) && ($urandom % 4 != 0);
         in_a      = pick_op();
         in_b      = pick_op();
         in_signed = 1'($urandom & 1);
         in_tag    = 4'($urandom);
         out_ready = ($urandom % 3 != 0);
         #1;
         if (vld4 && out_ready) begin
            checks++;
            if (q4.size() == 0) begin errors++; $display("FAIL rand4_spurious: got p=%h want no output", prod4); end
            else begin
               e = q4.pop_front();
               if (prod4 !== e.p[7:0] || tag4 !== e.t)
                  begin errors++; $display("FAIL rand4_result: got p=%h t=%0d want p=%h t=%0d", prod4, tag4, e.p[7:0], e.t); end
            end
         end
         if (vld8 && out_ready) begin
            checks++;
            if (q8.size() == 0) begin errors++; $display("FAIL rand8_spurious: got p=%h want no output", prod8); end
            else begin
               e = q8.pop_front();
               if (prod8 !== e.p[15:0] || tag8 !== e.t)
                  begin errors++; $display("FAIL rand8_result: got p=%h t=%0d want p=%h t=%0d", prod8, tag8, e.p[15:0], e.t); end
            end
         end
         if (vld16 && out_ready) begin
            checks++;
            if (q16.size() == 0) begin errors++; $display("FAIL rand16_spurious: got p=%h want no output", prod16); end
            else begin
               e = q16.pop_front();
               if (prod16 !== e.p || tag16 !== e.t)
                  begin errors++; $display("FAIL rand16_result: got p=%h t=%0d want p=%h t=%0d", prod16, tag16, e.p, e.t); end
            end
         end
         e.t = in_tag;
         if (in_valid && rdy4)  begin e.p = ref_mul(4,  in_a, in_b, in_signed); q4.push_back(e);  end
         if (in_valid && rdy16) begin e.p = ref_mul(16, in_a, in_b, in_signed); q16.push_back(e); end
         if (in_valid && rdy8)  begin e.p = ref_mul(8,  in_a, in_b, in_signed); q8.push_back(e); issued++; end
         @(posedge clk);
         cyc++;
      end
      checks++;
      if (issued != N || q4.size() != 0 || q8.size() != 0 || q16.size() != 0)
         begin errors++; $display("FAIL rand_timeout: issued %0d of %0d, pending %0d/%0d/%0d want 0/0/0",
                                  issued, N, q4.size(), q8.size(), q16.size()); end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
